// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding and PC arithmetic constants.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } fetch_state_e;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned PC_READ_OFFSET = 8;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, data/acknowledge back.
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ack);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// Request-age counter; tc_o flags the last cycle a request may wait before being abandoned.
module fetch_timeout_ctr #(
    parameter int unsigned Limit = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);
    localparam int unsigned W = (Limit > 2) ? $clog2(Limit) : 1;

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == W'(Limit - 1));
endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: holds the PC, reads one word per fetch, and feeds the extender/decoder.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_start,
    input  logic                      pc_load,
    input  logic [31:0]               pc_next,
    instr_fetch_unit_if.master        mem,
    output logic [31:0]               instr,
    output logic [23:0]               instr_imm,
    output logic [3:0]                instr_rot,
    output logic [31:0]               pc,
    output logic [31:0]               pc_plus8,
    output logic                      busy,
    output logic                      fetch_done,
    output logic                      fetch_err
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pend_pc_q, pend_pc_d;
    logic         pend_vld_q, pend_vld_d;
    logic         err_q, err_d;
    logic         cnt_clr, cnt_inc, cnt_tc;

    fetch_timeout_ctr #(
        .Limit(TIMEOUT)
    ) u_timeout_ctr (
        .clk  (clk),
        .reset(reset),
        .clr_i(cnt_clr),
        .inc_i(cnt_inc),
        .tc_o (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pend_pc_d  = pend_pc_q;
        pend_vld_d = pend_vld_q;
        err_d      = err_q;
        cnt_clr    = 1'b1;
        cnt_inc    = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                // Redirect lands before the fetch so the first request uses the new PC.
                if (pc_load) pc_d = align_word(pc_next);
                state_d = fetch_start ? StReq : StIdle;
            end
            StReq: begin
                if (mem.mem_ack) begin
                    instr_d = mem.mem_rdata;
                    if (pc_load) begin
                        pc_d = align_word(pc_next);
                    end else if (pend_vld_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_q + 32'(WORD_BYTES);
                    end
                    pend_vld_d = 1'b0;
                    state_d    = StDone;
                end else if (cnt_tc) begin
                    err_d      = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = StIdle;
                end else begin
                    cnt_clr = 1'b0;
                    cnt_inc = 1'b1;
                    if (pc_load) begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = align_word(pc_next);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pend_pc_q  <= 32'h0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    assign mem.mem_req  = (state_q == StReq);
    assign mem.mem_addr = pc_q;
    assign busy         = (state_q == StReq);
    assign fetch_done   = (state_q == StDone);
    assign fetch_err    = err_q;
    assign instr        = instr_q;
    assign instr_imm    = instr_q[23:0];
    assign instr_rot    = instr_q[11:8];
    assign pc           = pc_q;
    assign pc_plus8     = pc_q + 32'(PC_READ_OFFSET);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a word-level fetch model.
module tb_instr_fetch_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_start = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic [31:0] instr, pc, pc_plus8;
    logic [23:0] instr_imm;
    logic [3:0]  instr_rot;
    logic        busy, fetch_done, fetch_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc, m_instr;
    logic        m_err;

    instr_fetch_unit_if mem_if ();

    instr_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_start(fetch_start),
        .pc_load    (pc_load),
        .pc_next    (pc_next),
        .mem        (mem_if.master),
        .instr      (instr),
        .instr_imm  (instr_imm),
        .instr_rot  (instr_rot),
        .pc         (pc),
        .pc_plus8   (pc_plus8),
        .busy       (busy),
        .fetch_done (fetch_done),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch and records what the memory side saw; comparisons are done by callers.
    task automatic run_fetch(input int delay, input logic [31:0] data, input int redir_at,
                             input logic [31:0] redir, input logic idle_load,
                             input logic [31:0] idle_tgt, output int req_cycles,
                             output logic addr_stable, output logic [31:0] first_addr,
                             output int done_pulses);
        fetch_start = 1'b1;
        pc_load     = idle_load;
        pc_next     = idle_tgt;
        step();
        fetch_start = 1'b0;
        pc_load     = 1'b0;
        req_cycles  = 0;
        done_pulses = 0;
        addr_stable = 1'b1;
        first_addr  = mem_if.mem_addr;
        for (int c = 0; c < 64 && mem_if.mem_req; c++) begin
            req_cycles++;
            if (mem_if.mem_addr !== first_addr) addr_stable = 1'b0;
            pc_load          = (c == redir_at);
            pc_next          = redir;
            mem_if.mem_ack   = (c == delay);
            mem_if.mem_rdata = (c == delay) ? data : $urandom;
            step();
            mem_if.mem_ack = 1'b0;
            pc_load        = 1'b0;
            if (fetch_done) done_pulses++;
        end
        step();
        if (fetch_done) done_pulses++;
    endtask

    task automatic model_fetch(input int delay, input logic [31:0] data, input int redir_at,
                               input logic [31:0] redir, input logic idle_load,
                               input logic [31:0] idle_tgt, output int exp_req,
                               output logic [31:0] exp_addr, output int exp_done);
        if (idle_load) m_pc = {idle_tgt[31:2], 2'b00};
        exp_addr = m_pc;
        if (delay < TMO) begin
            exp_req  = delay + 1;
            exp_done = 1;
            m_instr  = data;
            if (redir_at >= 0 && redir_at <= delay) m_pc = {redir[31:2], 2'b00};
            else m_pc = m_pc + 32'd4;
        end else begin
            exp_req  = TMO;
            exp_done = 0;
            m_err    = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
        n_checks++;
        if (pc !== 32'h0 || instr !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_regs: pc=%h instr=%h want pc=0 instr=0", pc, instr);
        end
        n_checks++;
        if ({mem_if.mem_req, busy, fetch_done, fetch_err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: req/busy/done/err=%b want 0000",
                     {mem_if.mem_req, busy, fetch_done, fetch_err});
        end
    endtask

    task automatic test_basic();
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_checks++;
        if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 32'h0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL basic_req: req=%b addr=%h busy=%b want 1 0 1",
                     mem_if.mem_req, mem_if.mem_addr, busy);
        end
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 32'hE3A0_1A05;
        step();
        mem_if.mem_ack = 1'b0;
        n_checks++;
        if (fetch_done !== 1'b1 || instr !== 32'hE3A0_1A05 || instr_imm !== 24'hA01A05 ||
            instr_rot !== 4'hA) begin
            n_errors++;
            $display("FAIL basic_instr: done=%b instr=%h imm=%h rot=%h want 1 e3a01a05 a01a05 a",
                     fetch_done, instr, instr_imm, instr_rot);
        end
        n_checks++;
        if (pc !== 32'd4 || pc_plus8 !== 32'd12 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_pc: pc=%h pc_plus8=%h busy=%b want 4 c 0", pc, pc_plus8, busy);
        end
        step();
        n_checks++;
        if (fetch_done !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done_pulse: done=%b want 0", fetch_done);
        end
        m_pc = 32'd4; m_instr = 32'hE3A0_1A05;
    endtask

    task automatic test_delayed();
        int rq, dn, erq, edn;
        logic st;
        logic [31:0] fa, ea, d;
        d = $urandom;
        model_fetch(3, d, -1, 32'h0, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(3, d, -1, 32'h0, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (rq !== 4 || st !== 1'b1 || fa !== 32'h4) begin
            n_errors++;
            $display("FAIL delayed_req: cycles=%0d stable=%b addr=%h want 4 1 4", rq, st, fa);
        end
        n_checks++;
        if (pc !== 32'h8 || dn !== 1 || instr !== d) begin
            n_errors++;
            $display("FAIL delayed_result: pc=%h done=%0d instr=%h want 8 1 %h", pc, dn, instr, d);
        end
    endtask

    task automatic test_redirect_busy();
        int rq, dn, erq, edn;
        logic st;
        logic [31:0] fa, ea, d;
        d = $urandom;
        model_fetch(2, d, 0, 32'h0000_0103, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(2, d, 0, 32'h0000_0103, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (pc !== 32'h100 || dn !== 1) begin
            n_errors++;
            $display("FAIL redirect_busy_pc: pc=%h done=%0d want 100 1", pc, dn);
        end
        d = $urandom;
        model_fetch(0, d, -1, 32'h0, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(0, d, -1, 32'h0, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (fa !== 32'h100 || pc !== 32'h104) begin
            n_errors++;
            $display("FAIL redirect_busy_next: addr=%h pc=%h want 100 104", fa, pc);
        end
    endtask

    task automatic test_redirect_with_start();
        int rq, dn, erq, edn;
        logic st;
        logic [31:0] fa, ea, d;
        d = $urandom;
        model_fetch(1, d, -1, 32'h0, 1'b1, 32'h200, erq, ea, edn);
        run_fetch(1, d, -1, 32'h0, 1'b1, 32'h200, rq, st, fa, dn);
        n_checks++;
        if (fa !== 32'h200 || pc !== 32'h204 || rq !== 2) begin
            n_errors++;
            $display("FAIL redirect_start: addr=%h pc=%h cycles=%0d want 200 204 2", fa, pc, rq);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        d1 = $urandom;
        d2 = $urandom;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = d1;
        step();
        mem_if.mem_ack = 1'b0;
        m_pc = m_pc + 32'd4;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        n_checks++;
        if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== m_pc || instr !== d1) begin
            n_errors++;
            $display("FAIL back_to_back_req: req=%b addr=%h instr=%h want 1 %h %h",
                     mem_if.mem_req, mem_if.mem_addr, instr, m_pc, d1);
        end
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = d2;
        step();
        mem_if.mem_ack = 1'b0;
        m_pc = m_pc + 32'd4;
        m_instr = d2;
        n_checks++;
        if (fetch_done !== 1'b1 || instr !== d2 || pc !== m_pc) begin
            n_errors++;
            $display("FAIL back_to_back_done: done=%b instr=%h pc=%h want 1 %h %h",
                     fetch_done, instr, pc, d2, m_pc);
        end
        step();
    endtask

    task automatic test_timeout();
        int rq, dn, erq, edn;
        logic st;
        logic [31:0] fa, ea, d, old_pc, old_instr;
        old_pc = m_pc;
        old_instr = m_instr;
        model_fetch(99, 32'h0, -1, 32'h0, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(99, 32'h0, -1, 32'h0, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (rq !== TMO || dn !== 0 || fetch_err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_flag: cycles=%0d done=%0d err=%b want %0d 0 1",
                     rq, dn, fetch_err, TMO);
        end
        n_checks++;
        if (pc !== old_pc || instr !== old_instr || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_state: pc=%h instr=%h busy=%b want %h %h 0",
                     pc, instr, busy, old_pc, old_instr);
        end
        d = $urandom;
        model_fetch(1, d, -1, 32'h0, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(1, d, -1, 32'h0, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (fetch_err !== 1'b1 || pc !== m_pc || dn !== 1) begin
            n_errors++;
            $display("FAIL timeout_sticky: err=%b pc=%h done=%0d want 1 %h 1", fetch_err, pc,
                     dn, m_pc);
        end
    endtask

    task automatic test_random();
        int rq, dn, erq, edn, delay, rat;
        logic st, il;
        logic [31:0] fa, ea, d, rt, it;
        for (int i = 0; i < 40; i++) begin
            delay = $urandom_range(0, TMO + 1);
            d     = $urandom;
            rt    = $urandom;
            it    = $urandom;
            il    = ($urandom_range(0, 3) == 0);
            rat   = -1;
            if (delay < TMO && $urandom_range(0, 1) == 1) rat = $urandom_range(0, delay);
            model_fetch(delay, d, rat, rt, il, it, erq, ea, edn);
            run_fetch(delay, d, rat, rt, il, it, rq, st, fa, dn);
            n_checks++;
            if (rq !== erq || st !== 1'b1 || fa !== ea || dn !== edn) begin
                n_errors++;
                $display("FAIL random_bus[%0d]: cycles=%0d stable=%b addr=%h done=%0d want %0d 1 %h %0d",
                         i, rq, st, fa, dn, erq, ea, edn);
            end
            n_checks++;
            if (pc !== m_pc || pc_plus8 !== m_pc + 32'd8 || instr !== m_instr ||
                instr_imm !== m_instr[23:0] || instr_rot !== m_instr[11:8] ||
                fetch_err !== m_err) begin
                n_errors++;
                $display("FAIL random_state[%0d]: pc=%h p8=%h instr=%h imm=%h rot=%h err=%b want %h %h %h %h %h %b",
                         i, pc, pc_plus8, instr, instr_imm, instr_rot, fetch_err, m_pc,
                         m_pc + 32'd8, m_instr, m_instr[23:0], m_instr[11:8], m_err);
            end
        end
    endtask

    task automatic test_reset_mid_and_wrap();
        int rq, dn, erq, edn;
        logic st;
        logic [31:0] fa, ea, d;
        int pulses;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        mem_if.mem_ack = 1'b1;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_if.mem_ack = 1'b0;
        pulses = fetch_done ? 1 : 0;
        step();
        if (fetch_done) pulses++;
        m_pc = 32'h0; m_instr = 32'h0; m_err = 1'b0;
        n_checks++;
        if (pc !== 32'h0 || instr !== 32'h0 || mem_if.mem_req !== 1'b0 || pulses !== 0 ||
            fetch_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: pc=%h instr=%h req=%b pulses=%0d err=%b want 0 0 0 0 0",
                     pc, instr, mem_if.mem_req, pulses, fetch_err);
        end
        pc_load = 1'b1;
        pc_next = 32'hFFFF_FFFC;
        step();
        pc_load = 1'b0;
        m_pc = 32'hFFFF_FFFC;
        n_checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus8 !== 32'h4) begin
            n_errors++;
            $display("FAIL wrap_plus8: pc=%h pc_plus8=%h want fffffffc 4", pc, pc_plus8);
        end
        d = $urandom;
        model_fetch(0, d, -1, 32'h0, 1'b0, 32'h0, erq, ea, edn);
        run_fetch(0, d, -1, 32'h0, 1'b0, 32'h0, rq, st, fa, dn);
        n_checks++;
        if (fa !== 32'hFFFF_FFFC || pc !== 32'h0 || instr !== d) begin
            n_errors++;
            $display("FAIL wrap_fetch: addr=%h pc=%h instr=%h want fffffffc 0 %h", fa, pc,
                     instr, d);
        end
    endtask

    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        test_reset();
        test_basic();
        test_delayed();
        test_redirect_busy();
        test_redirect_with_start();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid_and_wrap();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
